aud_rec_writer: RTL and testbench



---
 rtl/aud_rec_writer.sv | 180 ++++++++++++++++++
 tb/tb_aud_rec_writer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_rec_writer.sv
// Recording-side SRAM writer: captures the left-channel I2S ADC sample and
// writes it to consecutive SRAM addresses, publishing the last written address.
module aud_rec_writer #(
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        ADDR_W    = 20,
    parameter logic [ADDR_W-1:0]  ADDR_MAX  = {ADDR_W{1'b1}},
    parameter int unsigned        WE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_is_recording,
    output logic              o_is_pause,
    output logic              o_done
);

    localparam int unsigned CntW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WeCntW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StShift,
        StWrite,
        StPause
    } state_e;

    state_e              state_q, state_d;
    logic                lrc_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [WeCntW-1:0]   we_cnt_q, we_cnt_d;
    logic                we_q, we_d;
    logic                stop_pend_q, stop_pend_d;
    logic                pause_pend_q, pause_pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stop_addr_q, stop_addr_d;
    logic                done_q, done_d;

    logic                lrc_fall;
    logic [DATA_W-1:0]   shift_nxt;

    assign lrc_fall  = lrc_q & ~i_lrc;
    assign shift_nxt = {shift_q[DATA_W-2:0], i_data};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        we_cnt_d     = we_cnt_q;
        we_d         = 1'b0;
        stop_pend_d  = stop_pend_q;
        pause_pend_d = pause_pend_q;
        addr_d       = addr_q;
        stop_addr_d  = stop_addr_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start && !i_stop) begin
                    state_d     = StWait;
                    addr_d      = '0;
                    stop_addr_d = '0;
                end
            end
            StWait: begin
                if (i_stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (i_pause) begin
                    state_d = StPause;
                end else if (lrc_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (i_stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (i_pause) begin
                    state_d = StPause;
                end else if (lrc_fall) begin
                    cnt_d = '0;
                end else if (i_lrc) begin
                    // Right channel began before the sample completed: drop it.
                    state_d = StWait;
                end else begin
                    shift_d = shift_nxt;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d      = StWrite;
                        data_d       = shift_nxt;
                        we_d         = 1'b1;
                        we_cnt_d     = '0;
                        stop_pend_d  = 1'b0;
                        pause_pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                // Control pulses are deferred so the strobe always completes.
                stop_pend_d  = stop_pend_q | i_stop;
                pause_pend_d = pause_pend_q | i_pause;
                if (we_cnt_q == WeCntW'(WE_CYCLES - 1)) begin
                    stop_addr_d = addr_q;
                    if (stop_pend_d || (addr_q == ADDR_MAX)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = pause_pend_d ? StPause : StWait;
                    end
                end else begin
                    we_d     = 1'b1;
                    we_cnt_d = we_cnt_q + 1'b1;
                end
            end
            StPause: begin
                if (i_stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (i_pause) begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            lrc_q        <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            we_cnt_q     <= '0;
            we_q         <= 1'b0;
            stop_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            addr_q       <= '0;
            stop_addr_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_q        <= i_lrc;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            we_cnt_q     <= we_cnt_d;
            we_q         <= we_d;
            stop_pend_q  <= stop_pend_d;
            pause_pend_q <= pause_pend_d;
            addr_q       <= addr_d;
            stop_addr_q  <= stop_addr_d;
            done_q       <= done_d;
        end
    end

    assign o_sram_addr    = addr_q;
    assign o_sram_data    = data_q;
    assign o_sram_we      = we_q;
    assign o_stop_addr    = stop_addr_q;
    assign o_is_recording = (state_q != StIdle);
    assign o_is_pause     = (state_q == StPause);
    assign o_done         = done_q;

endmodule

// File: tb/tb_aud_rec_writer.sv
// Self-checking bench for aud_rec_writer: directed frame table, randomized
// frames against a behavioural recorder model, ADDR_MAX limit and async reset.
module tb_aud_rec_writer;

    localparam int EvNone   = 0;
    localparam int EvPause  = 1;
    localparam int EvStop   = 2;
    localparam int EvGlitch = 3;
    localparam int MaxMain  = 32'h000F_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pause, stop, lrc, data;

    logic [19:0] addr, stop_addr;
    logic [15:0] sdata;
    logic        we, rec, pse, done;

    logic [19:0] addr3, stop3;
    logic [15:0] sdata3;
    logic        we3, rec3, pse3, done3;

    always #5 clk = ~clk;

    aud_rec_writer u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_lrc         (lrc),
        .i_data        (data),
        .o_sram_addr   (addr),
        .o_sram_data   (sdata),
        .o_sram_we     (we),
        .o_stop_addr   (stop_addr),
        .o_is_recording(rec),
        .o_is_pause    (pse),
        .o_done        (done)
    );

    aud_rec_writer #(.ADDR_MAX(20'd3)) u_dut3 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_lrc         (lrc),
        .i_data        (data),
        .o_sram_addr   (addr3),
        .o_sram_data   (sdata3),
        .o_sram_we     (we3),
        .o_stop_addr   (stop3),
        .o_is_recording(rec3),
        .o_is_pause    (pse3),
        .o_done        (done3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural recorder model: what a recording session should write.
    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    bit  m_rec   = 1'b0;
    bit  m_pause = 1'b0;
    int  m_addr  = 0;
    int  m_stop  = 0;
    int  m_done  = 0;
    int  m_nwr   = 0;

    task automatic model_frame(input int pre, input logic [15:0] s, input int ev,
                               input int pos, output bit tim);
        bit h_start, h_stop, h_pause, wr;
        tim     = 1'b0;
        h_start = (pre == 1) || (pre == 5);
        h_stop  = (pre == 3) || (pre == 5) || (pre == 6);
        h_pause = (pre == 2) || (pre == 6);
        if (!m_rec) begin
            if (h_start && !h_stop) begin
                m_rec   = 1'b1;
                m_pause = 1'b0;
                m_addr  = 0;
                m_stop  = 0;
            end
        end else if (h_stop) begin
            m_rec   = 1'b0;
            m_pause = 1'b0;
            m_done++;
        end else if (h_pause) begin
            m_pause = !m_pause;
        end
        if (!m_rec) return;
        if (m_pause) begin
            if (ev == EvStop) begin
                m_rec   = 1'b0;
                m_pause = 1'b0;
                m_done++;
            end else if (ev == EvPause) begin
                m_pause = 1'b0;
            end
            return;
        end
        // Events landing in the strobe window let the write complete.
        wr = (ev == EvNone) || (pos >= 16);
        if (wr) begin
            exp_q.push_back('{addr: m_addr, data: s});
            m_nwr++;
            m_stop = m_addr;
            tim    = (ev == EvNone);
            if (m_addr == MaxMain) begin
                m_rec = 1'b0;
                m_done++;
            end else begin
                m_addr++;
            end
        end
        if (ev == EvStop && m_rec) begin
            m_rec = 1'b0;
            m_done++;
        end else if (ev == EvPause && m_rec) begin
            m_pause = 1'b1;
        end
    endtask

    // Output monitor: strobe width/stability, scoreboard, done pulses.
    int          obs_done = 0;
    int          obs_nwr  = 0;
    int          q3[$];
    int          done3_cnt = 0;

    initial begin
        int          run = 0;
        int          done_run = 0;
        logic [19:0] r_addr = '0;
        logic [15:0] r_data = '0;
        bit          r_stable = 1'b1;
        logic        we3_prev = 1'b0;
        logic        done3_prev = 1'b0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run        = 0;
                done_run   = 0;
                we3_prev   = 1'b0;
                done3_prev = 1'b0;
            end else begin
                if (we) begin
                    if (run == 0) begin
                        r_addr   = addr;
                        r_data   = sdata;
                        r_stable = 1'b1;
                    end else if (addr !== r_addr || sdata !== r_data) begin
                        r_stable = 1'b0;
                    end
                    run++;
                end else if (run != 0) begin
                    check("we_width", 32'(run), 32'd2);
                    check("wr_stable", 32'(r_stable), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                                 r_addr, r_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(r_addr), 32'(e.addr));
                        check("wr_data", 32'(r_data), 32'(e.data));
                    end
                    obs_nwr++;
                    run = 0;
                end
                if (done) begin
                    done_run++;
                end else if (done_run != 0) begin
                    check("done_width", 32'(done_run), 32'd1);
                    obs_done++;
                    done_run = 0;
                end
                if (we3 && !we3_prev) q3.push_back(int'(addr3));
                if (done3 && !done3_prev) done3_cnt++;
                we3_prev   = we3;
                done3_prev = done3;
            end
        end
    end

    // One I2S frame: right half (with optional control pulse), then left half.
    task automatic send_frame(input int pre, input logic [15:0] s, input int ev, input int pos);
        bit tim;
        bit glitch;
        model_frame(pre, s, ev, pos, tim);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            lrc   = 1'b1;
            data  = 1'($urandom());
            start = (c == 8) && (pre == 1 || pre == 5);
            pause = (c == 8) && (pre == 2 || pre == 6);
            stop  = (c == 8) && (pre == 3 || pre == 5 || pre == 6);
        end
        glitch = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (tim) begin
                if (c == 16) check("we_before_k17", 32'(we), 32'd0);
                if (c == 17) check("we_at_k17", 32'(we), 32'd1);
                if (c == 19) check("we_after_k18", 32'(we), 32'd0);
            end
            if (ev == EvGlitch && c == pos + 1) glitch = 1'b1;
            lrc   = glitch;
            data  = (c >= 1 && c <= 16) ? s[16-c] : 1'($urandom());
            start = 1'b0;
            pause = (ev == EvPause) && (c == pos + 1);
            stop  = (ev == EvStop) && (c == pos + 1);
        end
    endtask

    task automatic check_model();
        check("is_recording", 32'(rec), 32'(m_rec));
        check("is_pause", 32'(pse), 32'(m_pause));
        check("stop_addr", 32'(stop_addr), 32'(m_stop));
        check("done_count", 32'(obs_done), 32'(m_done));
        check("write_count", 32'(obs_nwr), 32'(m_nwr));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        stop    = 1'b0;
        lrc     = 1'b1;
        m_rec   = 1'b0;
        m_pause = 1'b0;
        m_addr  = 0;
        m_stop  = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        int          pre;
        logic [15:0] s;
        int          ev;
        int          pos;
        bit          rec;
        bit          pse;
        int          stop;
        int          nwr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int r, pre, ev, pos;
        bit tim;

        // pre: 0 none, 1 start, 2 pause, 3 stop, 5 start+stop, 6 pause+stop
        tbl[0]  = '{1, 16'hA5C3, EvNone,    0, 1'b1, 1'b0, 0, 1};
        tbl[1]  = '{1, 16'h0001, EvNone,    0, 1'b1, 1'b0, 1, 2};
        tbl[2]  = '{0, 16'h8000, EvNone,    0, 1'b1, 1'b0, 2, 3};
        tbl[3]  = '{0, 16'h7FFF, EvNone,    0, 1'b1, 1'b0, 3, 4};
        tbl[4]  = '{3, 16'h1111, EvNone,    0, 1'b0, 1'b0, 3, 4};
        tbl[5]  = '{1, 16'h2222, EvPause,   8, 1'b1, 1'b1, 0, 4};
        tbl[6]  = '{0, 16'h3333, EvNone,    0, 1'b1, 1'b1, 0, 4};
        tbl[7]  = '{2, 16'h1234, EvNone,    0, 1'b1, 1'b0, 0, 5};
        tbl[8]  = '{0, 16'h4444, EvGlitch, 10, 1'b1, 1'b0, 0, 5};
        tbl[9]  = '{0, 16'h5555, EvNone,    0, 1'b1, 1'b0, 1, 6};
        tbl[10] = '{0, 16'h6666, EvStop,   16, 1'b0, 1'b0, 2, 7};
        tbl[11] = '{0, 16'h7777, EvNone,    0, 1'b0, 1'b0, 2, 7};
        tbl[12] = '{5, 16'h8888, EvNone,    0, 1'b0, 1'b0, 2, 7};
        tbl[13] = '{1, 16'h9999, EvPause,  17, 1'b1, 1'b1, 0, 8};
        tbl[14] = '{6, 16'hAAAA, EvNone,    0, 1'b0, 1'b0, 0, 8};
        tbl[15] = '{1, 16'hBEEF, EvStop,    5, 1'b0, 1'b0, 0, 8};

        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        lrc   = 1'b1;
        data  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(sdata), 32'd0);
        check("rst_stop_addr", 32'(stop_addr), 32'd0);
        check("rst_flags", 32'({rec, pse, done}), 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            send_frame(tbl[i].pre, tbl[i].s, tbl[i].ev, tbl[i].pos);
            check($sformatf("tbl%0d_rec", i), 32'(rec), 32'(tbl[i].rec));
            check($sformatf("tbl%0d_pause", i), 32'(pse), 32'(tbl[i].pse));
            check($sformatf("tbl%0d_stop_addr", i), 32'(stop_addr), 32'(tbl[i].stop));
            check($sformatf("tbl%0d_writes", i), 32'(obs_nwr), 32'(tbl[i].nwr));
            check($sformatf("tbl%0d_done", i), 32'(obs_done), 32'(m_done));
        end

        for (int i = 0; i < 120; i++) begin
            r   = int'($urandom_range(99, 0));
            pre = (r < 12) ? 1 : (r < 20) ? 2 : (r < 25) ? 3 : (r < 27) ? 5 : (r < 29) ? 6 : 0;
            r   = int'($urandom_range(99, 0));
            ev  = (r < 60) ? EvNone : (r < 70) ? EvPause : (r < 75) ? EvStop :
                  (r < 90) ? EvGlitch : EvNone;
            pos = int'($urandom_range(17, 0));
            send_frame(pre, 16'($urandom()), ev, pos);
            check_model();
        end

        // Address limit on the ADDR_MAX=3 instance: fifth frame must be dropped.
        apply_reset();
        q3.delete();
        done3_cnt = 0;
        send_frame(1, 16'($urandom()), EvNone, 0);
        for (int i = 0; i < 4; i++) send_frame(0, 16'($urandom()), EvNone, 0);
        check("max_writes", 32'(q3.size()), 32'd4);
        for (int i = 0; i < q3.size(); i++) check($sformatf("max_addr%0d", i), 32'(q3[i]), 32'(i));
        check("max_done", 32'(done3_cnt), 32'd1);
        check("max_stop_addr", 32'(stop3), 32'd3);
        check("max_rec", 32'(rec3), 32'd0);
        check_model();

        // Asynchronous reset in the middle of a write strobe.
        send_frame(1, 16'h1357, EvNone, 0);
        model_frame(0, 16'h2468, EvNone, 0, tim);
        void'(exp_q.pop_back());
        m_nwr--;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            lrc  = 1'b1;
            data = 1'($urandom());
        end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            lrc  = 1'b0;
            data = (c >= 1 && c <= 16) ? 1'($urandom()) : 1'b0;
        end
        @(negedge clk);
        check("midrst_we_before", 32'(we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_data", 32'(sdata), 32'd0);
        check("midrst_stop_addr", 32'(stop_addr), 32'd0);
        check("midrst_flags", 32'({rec, pse, done}), 32'd0);
        m_rec   = 1'b0;
        m_pause = 1'b0;
        m_addr  = 0;
        m_stop  = 0;
        lrc     = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        send_frame(1, 16'hC0DE, EvNone, 0);
        send_frame(0, 16'hF00D, EvNone, 0);
        check_model();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
